// File: rtl/quantum_scheduler_if.sv
// Scheduler <-> core bundle: retire/OS-control inputs and PC redirect/status outputs.
interface quantum_scheduler_if #(
   parameter int unsigned ADDR_W = 32
);
   logic [ADDR_W-1:0] pc_current;
   logic              instr_valid;
   logic              qtm_load;
   logic [31:0]       qtm_value;
   logic              user_enter;
   logic [ADDR_W-1:0] user_target;
   logic              halt;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic [ADDR_W-1:0] saved_pc;
   logic              user_mode;
   logic [31:0]       quantum_left;
   logic [15:0]       preempt_count;
   logic              halted;

   // Core / OS side: drives retire and control, consumes redirect and status.
   modport master (
      output pc_current, instr_valid, qtm_load, qtm_value, user_enter, user_target, halt,
      input  redirect, redirect_pc, saved_pc, user_mode, quantum_left, preempt_count, halted
   );

   // Scheduler side.
   modport slave (
      input  pc_current, instr_valid, qtm_load, qtm_value, user_enter, user_target, halt,
      output redirect, redirect_pc, saved_pc, user_mode, quantum_left, preempt_count, halted
   );
endinterface

// File: rtl/quantum_scheduler.sv
// Time-slice controller upstream of the PC: counts user instructions against an
// OS-programmed quantum, preempts to the OS entry on expiry, and performs the
// OS-to-user return redirect.
module quantum_scheduler #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned OS_LIMIT = 616,
   parameter int unsigned OS_ENTRY = 0,
   parameter int unsigned PC_STEP  = 1
) (
   input logic                 clock,
   input logic                 reset,
   quantum_scheduler_if.slave  bus
);
   localparam logic [ADDR_W-1:0] OS_LIMIT_A = ADDR_W'(OS_LIMIT);
   localparam logic [ADDR_W-1:0] OS_ENTRY_A = ADDR_W'(OS_ENTRY);
   localparam logic [ADDR_W-1:0] PC_STEP_A  = ADDR_W'(PC_STEP);

   typedef enum logic [1:0] {
      ST_OS      = 2'd0,
      ST_USER    = 2'd1,
      ST_PREEMPT = 2'd2,
      ST_HALT    = 2'd3
   } state_t;

   state_t      state;
   logic [31:0] limit;
   logic [31:0] count;

   logic [32:0] count_inc;
   logic        user_space_pc;
   logic        expiry;
   logic        enter_ok;

   // Event decode; increment is 33 bits so the compare never wraps.
   assign count_inc     = {1'b0, count} + 33'd1;
   assign user_space_pc = (bus.pc_current >= OS_LIMIT_A);
   assign expiry        = bus.instr_valid && (limit != 32'd0) && (count_inc >= {1'b0, limit});
   assign enter_ok      = bus.user_enter && (bus.user_target >= OS_LIMIT_A);

   // Remaining quantum is a pure function of the state, limit and count flops.
   assign bus.quantum_left = ((state == ST_USER) && (limit != 32'd0)) ? (limit - count)
                                                                       : 32'hFFFF_FFFF;

   // Scheduler state machine with registered redirect and status outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state             <= ST_OS;
         limit             <= 32'd0;
         count             <= 32'd0;
         bus.saved_pc      <= '0;
         bus.redirect_pc   <= '0;
         bus.preempt_count <= 16'd0;
         bus.redirect      <= 1'b0;
         bus.user_mode     <= 1'b0;
         bus.halted        <= 1'b0;
      end else begin
         bus.redirect <= 1'b0;

         // Quantum reprogramming is independent of the state transitions below.
         if ((state != ST_HALT) && bus.qtm_load) begin
            limit <= bus.qtm_value;
         end

         if (bus.halt) begin
            state         <= ST_HALT;
            bus.halted    <= 1'b1;
            bus.user_mode <= 1'b0;
         end else begin
            case (state)
               ST_OS: begin
                  if (enter_ok) begin
                     state           <= ST_USER;
                     count           <= 32'd0;
                     bus.redirect    <= 1'b1;
                     bus.redirect_pc <= bus.user_target;
                     bus.user_mode   <= 1'b1;
                  end
               end
               ST_USER: begin
                  if (expiry) begin
                     state           <= ST_PREEMPT;
                     count           <= 32'd0;
                     bus.saved_pc    <= bus.pc_current + PC_STEP_A;
                     bus.redirect    <= 1'b1;
                     bus.redirect_pc <= OS_ENTRY_A;
                     bus.user_mode   <= 1'b0;
                     if (bus.preempt_count != 16'hFFFF) begin
                        bus.preempt_count <= bus.preempt_count + 16'd1;
                     end
                  end else if (bus.instr_valid && !user_space_pc) begin
                     state         <= ST_OS;
                     count         <= 32'd0;
                     bus.user_mode <= 1'b0;
                  end else if (bus.instr_valid) begin
                     count <= count_inc[31:0];
                  end
               end
               ST_PREEMPT: begin
                  // In-flight instruction and user_enter are squashed here.
                  state <= ST_OS;
               end
               default: begin
                  state <= ST_HALT;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_quantum_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic, every cycle
// compared against an event-level reference model of the scheduler.
module tb_quantum_scheduler;
   localparam int unsigned ADDR_W   = 32;
   localparam longint      OS_LIM   = 616;

   localparam int M_OS = 0, M_USER = 1, M_PREEMPT = 2, M_HALT = 3;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   quantum_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

   quantum_scheduler #(
      .ADDR_W  (ADDR_W),
      .OS_LIMIT(616),
      .OS_ENTRY(0),
      .PC_STEP (1)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   int     m_mode;
   longint m_limit, m_count, m_saved, m_rpc, m_pcnt;
   bit     m_redir;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
   endtask

   task automatic idle_inputs();
      reset           = 1'b0;
      bus.pc_current  = '0;
      bus.instr_valid = 1'b0;
      bus.qtm_load    = 1'b0;
      bus.qtm_value   = '0;
      bus.user_enter  = 1'b0;
      bus.user_target = '0;
      bus.halt        = 1'b0;
   endtask

   // Apply one clock edge to the model using the inputs as driven this cycle.
   task automatic model_step();
      longint new_limit;
      if (reset) begin
         m_mode = M_OS; m_limit = 0; m_count = 0; m_saved = 0; m_rpc = 0; m_pcnt = 0;
         m_redir = 1'b0;
         return;
      end
      m_redir   = 1'b0;
      new_limit = (m_mode != M_HALT && bus.qtm_load) ? longint'(bus.qtm_value) : m_limit;
      if (bus.halt) begin
         m_mode = M_HALT;
      end else if (m_mode == M_OS) begin
         if (bus.user_enter && longint'(bus.user_target) >= OS_LIM) begin
            m_mode = M_USER; m_count = 0; m_redir = 1'b1; m_rpc = longint'(bus.user_target);
         end
      end else if (m_mode == M_USER) begin
         if (bus.instr_valid) begin
            if (m_limit != 0 && m_count + 1 >= m_limit) begin
               m_mode  = M_PREEMPT;
               m_saved = (longint'(bus.pc_current) + 1) % (64'd1 << 32);
               m_rpc   = 0;
               m_redir = 1'b1;
               m_count = 0;
               if (m_pcnt < 65535) m_pcnt = m_pcnt + 1;
            end else if (longint'(bus.pc_current) < OS_LIM) begin
               m_mode = M_OS; m_count = 0;
            end else begin
               m_count = (m_count + 1) % (64'd1 << 32);
            end
         end
      end else if (m_mode == M_PREEMPT) begin
         m_mode = M_OS;
      end
      m_limit = new_limit;
   endtask

   task automatic compare_all();
      longint exp_ql;
      exp_ql = (m_mode == M_USER && m_limit != 0) ? ((m_limit - m_count) & 64'hFFFF_FFFF)
                                                  : 64'hFFFF_FFFF;
      check("redirect",      64'(bus.redirect),      64'(m_redir));
      check("redirect_pc",   64'(bus.redirect_pc),   m_rpc);
      check("saved_pc",      64'(bus.saved_pc),      m_saved);
      check("user_mode",     64'(bus.user_mode),     64'(m_mode == M_USER));
      check("halted",        64'(bus.halted),        64'(m_mode == M_HALT));
      check("quantum_left",  64'(bus.quantum_left),  exp_ql);
      check("preempt_count", 64'(bus.preempt_count), m_pcnt);
   endtask

   // One cycle: inputs already driven; model and DUT take the same edge.
   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      compare_all();
      idle_inputs();
   endtask

   task automatic do_reset();
      idle_inputs(); reset = 1'b1; tick();
   endtask
   task automatic do_load(input logic [31:0] v);
      bus.qtm_load = 1'b1; bus.qtm_value = v; tick();
   endtask
   task automatic do_enter(input logic [31:0] t);
      bus.user_enter = 1'b1; bus.user_target = t; tick();
   endtask
   task automatic do_instr(input logic [31:0] pc, input logic h);
      bus.instr_valid = 1'b1; bus.pc_current = pc; bus.halt = h; tick();
   endtask

   initial begin
      idle_inputs();
      @(negedge clock);

      // Reset values
      do_reset();
      check("rst_redirect", 64'(bus.redirect), 64'd0);
      check("rst_quantum_left", 64'(bus.quantum_left), 64'hFFFF_FFFF);

      // Basic preemption after a 3-instruction quantum
      do_load(32'd3);
      do_enter(32'd700);
      check("t1_enter_pc", 64'(bus.redirect_pc), 64'd700);
      check("t1_qleft", 64'(bus.quantum_left), 64'd3);
      do_instr(32'd700, 1'b0);
      do_instr(32'd701, 1'b0);
      do_instr(32'd702, 1'b0);
      check("t1_redirect", 64'(bus.redirect), 64'd1);
      check("t1_target", 64'(bus.redirect_pc), 64'd0);
      check("t1_saved", 64'(bus.saved_pc), 64'd703);
      check("t1_pcnt", 64'(bus.preempt_count), 64'd1);
      bus.instr_valid = 1'b1; bus.pc_current = 32'd703; tick();   // squashed in PREEMPT
      check("t1_pulse_end", 64'(bus.redirect), 64'd0);
      tick();

      // Quantum 0 never preempts
      do_load(32'd0);
      do_enter(32'd616);
      for (int i = 0; i < 100; i++) do_instr(32'(616 + i), 1'b0);
      check("t2_qleft", 64'(bus.quantum_left), 64'hFFFF_FFFF);
      check("t2_user", 64'(bus.user_mode), 64'd1);

      // Enter with an OS-space target is ignored
      do_reset();
      do_enter(32'd615);
      check("t3_redirect", 64'(bus.redirect), 64'd0);
      check("t3_user", 64'(bus.user_mode), 64'd0);

      // Syscall back to OS
      do_load(32'd5);
      do_enter(32'd700);
      do_instr(32'd700, 1'b0);
      do_instr(32'd701, 1'b0);
      do_instr(32'd10, 1'b0);
      check("t4_user", 64'(bus.user_mode), 64'd0);
      check("t4_redirect", 64'(bus.redirect), 64'd0);

      // Halt wins over simultaneous expiry, then only reset leaves HALT
      do_reset();
      do_load(32'd3);
      do_enter(32'd700);
      do_instr(32'd700, 1'b0);
      do_instr(32'd701, 1'b0);
      do_instr(32'd702, 1'b1);
      check("t5_halted", 64'(bus.halted), 64'd1);
      check("t5_redirect", 64'(bus.redirect), 64'd0);
      check("t5_saved", 64'(bus.saved_pc), 64'd0);
      do_enter(32'd800);
      check("t5_enter_ignored", 64'(bus.redirect), 64'd0);
      do_reset();
      check("t5_unhalt", 64'(bus.halted), 64'd0);

      // Lowering the limit mid-quantum
      do_load(32'd4);
      do_enter(32'd700);
      do_instr(32'd700, 1'b0);
      do_instr(32'd701, 1'b0);
      do_load(32'd2);
      do_instr(32'd702, 1'b0);
      check("t6_redirect", 64'(bus.redirect), 64'd1);
      check("t6_saved", 64'(bus.saved_pc), 64'd703);

      // Randomized traffic
      for (int i = 0; i < 5000; i++) begin
         int r;
         r = int'($urandom_range(0, 999));
         reset           = (r < 2) || (m_mode == M_HALT && r < 60);
         bus.halt        = (r >= 995);
         bus.qtm_load    = ($urandom_range(0, 15) == 0) && !bus.halt;
         bus.qtm_value   = 32'($urandom_range(0, 8));
         bus.user_enter  = ($urandom_range(0, 5) == 0);
         bus.user_target = 32'($urandom_range(600, 720));
         bus.instr_valid = ($urandom_range(0, 3) != 0);
         bus.pc_current  = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 615))
                                                        : 32'($urandom_range(616, 2000));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
